// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcodes, micro-step numbers and control word layout for the microsequencer
package control_unit_pkg;

  localparam int OPC_W  = 4;
  localparam int STEP_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP  = 4'h0,
    OPC_LDA  = 4'h1,
    OPC_LDI  = 4'h2,
    OPC_STA  = 4'h3,
    OPC_ADD  = 4'h4,
    OPC_SUB  = 4'h5,
    OPC_MOVB = 4'h6,
    OPC_JMP  = 4'h7,
    OPC_JC   = 4'h8,
    OPC_JZ   = 4'h9,
    OPC_HLT  = 4'hF
  } opcode_t;

  localparam logic [OPC_W-1:0] HALT_OPC = OPC_HLT;

  localparam logic [STEP_W-1:0] STEP_T0 = 3'd0;
  localparam logic [STEP_W-1:0] STEP_T1 = 3'd1;
  localparam logic [STEP_W-1:0] STEP_T2 = 3'd2;
  localparam logic [STEP_W-1:0] STEP_T3 = 3'd3;
  localparam logic [STEP_W-1:0] STEP_T4 = 3'd4;
  localparam logic [STEP_W-1:0] STEP_T5 = 3'd5;

  // flag_ld and halt are internal actions, not datapath strobes
  typedef struct packed {
    logic ai;
    logic ao;
    logic bi;
    logic bo;
    logic zi;
    logic zo;
    logic ii;
    logic io;
    logic co;
    logic ce;
    logic j;
    logic eo;
    logic sub;
    logic mi;
    logic ro;
    logic ri;
    logic flag_ld;
    logic halt;
  } ctrl_word_t;

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - datapath-facing signals of the microsequencer
interface control_unit_if;
  logic [7:0] instr;
  logic       alu_c;
  logic       alu_z;
  logic       c_ai, c_ao, c_bi, c_bo, c_zi, c_zo, c_ii, c_io;
  logic       c_co, c_ce, c_j, c_eo, c_sub, c_mi, c_ro, c_ri;
  logic       halted;
  logic [2:0] step;

  modport master (
    input  instr, alu_c, alu_z,
    output c_ai, c_ao, c_bi, c_bo, c_zi, c_zo, c_ii, c_io,
    output c_co, c_ce, c_j, c_eo, c_sub, c_mi, c_ro, c_ri,
    output halted, step
  );

  modport slave (
    output instr, alu_c, alu_z,
    input  c_ai, c_ao, c_bi, c_bo, c_zi, c_zo, c_ii, c_io,
    input  c_co, c_ce, c_j, c_eo, c_sub, c_mi, c_ro, c_ri,
    input  halted, step
  );
endinterface

// File: rtl/control_unit_microcode_rom.sv
// rtl/control_unit_microcode_rom.sv - combinational microcode: opcode/step/flags to control word and last-step marker
module microcode_rom
  import control_unit_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              flag_c_i,
  input  logic              flag_z_i,
  output ctrl_word_t        cw_o,
  output logic              last_o
);

  logic jump_taken;

  always_comb begin
    cw_o       = '0;
    last_o     = 1'b0;
    jump_taken = (opcode_i == OPC_JMP) ||
                 ((opcode_i == OPC_JC) && flag_c_i) ||
                 ((opcode_i == OPC_JZ) && flag_z_i);

    case (step_i)
      STEP_T0: begin
        cw_o.co = 1'b1;
        cw_o.mi = 1'b1;
      end
      STEP_T1: begin
        cw_o.ro = 1'b1;
        cw_o.ii = 1'b1;
        cw_o.ce = 1'b1;
      end
      STEP_T2: begin
        case (opcode_i)
          OPC_LDA, OPC_LDI, OPC_STA: begin
            cw_o.co = 1'b1;
            cw_o.mi = 1'b1;
          end
          OPC_ADD, OPC_SUB: begin
            cw_o.eo      = 1'b1;
            cw_o.ai      = 1'b1;
            cw_o.sub     = (opcode_i == OPC_SUB);
            cw_o.flag_ld = 1'b1;
            last_o       = 1'b1;
          end
          OPC_MOVB: begin
            cw_o.ao = 1'b1;
            cw_o.bi = 1'b1;
            last_o  = 1'b1;
          end
          OPC_JMP, OPC_JC, OPC_JZ: begin
            // an untaken branch still has to step the PC past its operand byte
            if (jump_taken) begin
              cw_o.co = 1'b1;
              cw_o.mi = 1'b1;
            end else begin
              cw_o.ce = 1'b1;
              last_o  = 1'b1;
            end
          end
          HALT_OPC: begin
            cw_o.halt = 1'b1;
            last_o    = 1'b1;
          end
          default: last_o = 1'b1;
        endcase
      end
      STEP_T3: begin
        case (opcode_i)
          OPC_LDA, OPC_STA: begin
            cw_o.ro = 1'b1;
            cw_o.mi = 1'b1;
            cw_o.ce = 1'b1;
          end
          OPC_LDI: begin
            cw_o.ro = 1'b1;
            cw_o.ai = 1'b1;
            cw_o.ce = 1'b1;
            last_o  = 1'b1;
          end
          OPC_JMP, OPC_JC, OPC_JZ: begin
            cw_o.ro = jump_taken;
            cw_o.j  = jump_taken;
            last_o  = 1'b1;
          end
          default: last_o = 1'b1;
        endcase
      end
      STEP_T4: begin
        case (opcode_i)
          OPC_LDA: begin
            cw_o.ro = 1'b1;
            cw_o.ai = 1'b1;
          end
          OPC_STA: begin
            cw_o.ao = 1'b1;
            cw_o.ri = 1'b1;
          end
          default: ;
        endcase
        last_o = 1'b1;
      end
      default: last_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - microsequencer: step counter, C/Z flags, halt latch and output gating
module control_unit
  import control_unit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  control_unit_if.master bus
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;
  logic              halted_q, halted_d;
  ctrl_word_t        cw;
  ctrl_word_t        cw_out;
  logic              last_step;

  microcode_rom u_rom (
    .opcode_i (bus.instr[7:4]),
    .step_i   (step_q),
    .flag_c_i (flag_c_q),
    .flag_z_i (flag_z_q),
    .cw_o     (cw),
    .last_o   (last_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= STEP_T0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    step_d   = step_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    halted_d = halted_q;
    if (!halted_q) begin
      step_d = last_step ? STEP_T0 : step_q + 3'd1;
      if (cw.flag_ld) begin
        flag_c_d = bus.alu_c;
        flag_z_d = bus.alu_z;
      end
      if (cw.halt) begin
        halted_d = 1'b1;
      end
    end
  end

  // reset gates combinationally so strobes drop in the same cycle reset rises
  assign cw_out = (reset || halted_q) ? '0 : cw;

  assign bus.c_ai   = cw_out.ai;
  assign bus.c_ao   = cw_out.ao;
  assign bus.c_bi   = cw_out.bi;
  assign bus.c_bo   = cw_out.bo;
  assign bus.c_zi   = cw_out.zi;
  assign bus.c_zo   = cw_out.zo;
  assign bus.c_ii   = cw_out.ii;
  assign bus.c_io   = cw_out.io;
  assign bus.c_co   = cw_out.co;
  assign bus.c_ce   = cw_out.ce;
  assign bus.c_j    = cw_out.j;
  assign bus.c_eo   = cw_out.eo;
  assign bus.c_sub  = cw_out.sub;
  assign bus.c_mi   = cw_out.mi;
  assign bus.c_ro   = cw_out.ro;
  assign bus.c_ri   = cw_out.ri;
  assign bus.halted = halted_q;
  assign bus.step   = step_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit against an instruction-level model
module tb_control_unit;

  typedef logic [15:0] mask_t;
  localparam mask_t AI  = mask_t'(1) << 15;
  localparam mask_t AO  = mask_t'(1) << 14;
  localparam mask_t BI  = mask_t'(1) << 13;
  localparam mask_t BO  = mask_t'(1) << 12;
  localparam mask_t ZI  = mask_t'(1) << 11;
  localparam mask_t ZO  = mask_t'(1) << 10;
  localparam mask_t II  = mask_t'(1) << 9;
  localparam mask_t IO  = mask_t'(1) << 8;
  localparam mask_t CO  = mask_t'(1) << 7;
  localparam mask_t CE  = mask_t'(1) << 6;
  localparam mask_t JJ  = mask_t'(1) << 5;
  localparam mask_t EO  = mask_t'(1) << 4;
  localparam mask_t SUB = mask_t'(1) << 3;
  localparam mask_t MI  = mask_t'(1) << 2;
  localparam mask_t RO  = mask_t'(1) << 1;
  localparam mask_t RI  = mask_t'(1) << 0;
  localparam mask_t DRIVERS = AO | BO | ZO | IO | CO | EO | RO;

  logic clk = 1'b0;
  logic reset;
  control_unit_if cu ();

  control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cu)
  );

  always #5 clk = ~clk;

  mask_t dmask;
  assign dmask = {cu.c_ai, cu.c_ao, cu.c_bi, cu.c_bo, cu.c_zi, cu.c_zo, cu.c_ii, cu.c_io,
                  cu.c_co, cu.c_ce, cu.c_j, cu.c_eo, cu.c_sub, cu.c_mi, cu.c_ro, cu.c_ri};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: the micro-step plan of one whole instruction
  function automatic void plan(input logic [3:0] opc, input bit fc, input bit fz,
                               output int len, output mask_t s [6]);
    bit taken;
    for (int i = 0; i < 6; i++) s[i] = '0;
    s[0] = CO | MI;
    s[1] = RO | II | CE;
    len  = 3;
    taken = (opc == 4'h7) || (opc == 4'h8 && fc) || (opc == 4'h9 && fz);
    case (opc)
      4'h1: begin s[2] = CO | MI; s[3] = RO | MI | CE; s[4] = RO | AI; len = 5; end
      4'h2: begin s[2] = CO | MI; s[3] = RO | AI | CE; len = 4; end
      4'h3: begin s[2] = CO | MI; s[3] = RO | MI | CE; s[4] = AO | RI; len = 5; end
      4'h4: s[2] = EO | AI;
      4'h5: s[2] = EO | AI | SUB;
      4'h6: s[2] = AO | BI;
      4'h7, 4'h8, 4'h9: begin
        if (taken) begin s[2] = CO | MI; s[3] = RO | JJ; len = 4; end
        else s[2] = CE;
      end
      default: ;
    endcase
  endfunction

  int    m_pos = 0;
  bit    m_fc = 0, m_fz = 0, m_halted = 0;
  mask_t exp_mask;
  int    exp_step;
  bit    exp_halted;
  bit    exp_valid = 0;
  mask_t last_dut;

  always @(negedge clk) begin
    if (exp_valid) begin
      check("ctrl", dmask, exp_mask);
      check("step", cu.step, exp_step);
      check("halted", cu.halted, exp_halted);
      check("onehot", ($countones(dmask & DRIVERS) > 1) ? 1 : 0, 0);
    end
  end

  // One clock: publish expectation for this cycle, then advance the model on the edge
  task automatic cycle();
    int    len;
    mask_t s [6];
    plan(cu.instr[7:4], m_fc, m_fz, len, s);
    exp_mask   = (reset || m_halted) ? '0 : s[m_pos];
    exp_step   = m_pos;
    exp_halted = m_halted;
    exp_valid  = 1'b1;
    #1;
    last_dut = dmask;
    @(posedge clk);
    if (reset) begin
      m_pos = 0; m_fc = 0; m_fz = 0; m_halted = 0;
    end else if (!m_halted) begin
      if (m_pos == 2 && (cu.instr[7:4] == 4'h4 || cu.instr[7:4] == 4'h5)) begin
        m_fc = cu.alu_c;
        m_fz = cu.alu_z;
      end
      if (m_pos == 2 && cu.instr[7:4] == 4'hF) m_halted = 1;
      m_pos = (m_pos == len - 1) ? 0 : m_pos + 1;
    end
    #1;
  endtask

  mask_t seen [8];

  task automatic exec(input logic [7:0] ins, input bit c, input bit z, output int n);
    cu.instr = ins;
    cu.alu_c = c;
    cu.alu_z = z;
    n = 0;
    do begin
      cycle();
      seen[n] = last_dut;
      n++;
    end while (!(m_pos == 0 || m_halted) && n < 8);
    if (n >= 8) check("exec_bound", n, 0);
  endtask

  int n;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    cu.instr = 8'h00;
    cu.alu_c = 1'b0;
    cu.alu_z = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cycle();
    check("reset_strobes", last_dut, 0);
    reset = 1'b0;

    exec(8'h00, 0, 0, n);
    check("nop_len", n, 3);
    check("fetch_t0", seen[0], CO | MI);
    check("fetch_t1", seen[1], RO | II | CE);

    exec(8'h21, 0, 0, n);
    check("ldi_len", n, 4);
    check("ldi_t2", seen[2], CO | MI);
    check("ldi_t3", seen[3], RO | AI | CE);

    exec(8'h40, 1, 0, n);
    check("add_t2", seen[2], EO | AI);
    exec(8'h80, 0, 0, n);
    check("jc_taken_len", n, 4);
    check("jc_taken_t3", seen[3], RO | JJ);

    exec(8'h40, 0, 0, n);
    exec(8'h80, 1, 1, n);
    check("jc_skip_len", n, 3);
    check("jc_skip_t2", seen[2], CE);

    exec(8'h50, 0, 1, n);
    check("sub_t2", seen[2], EO | AI | SUB);
    exec(8'h60, 0, 0, n);
    check("movb_t2", seen[2], AO | BI);
    exec(8'h90, 0, 0, n);
    check("jz_taken_len", n, 4);
    check("jz_taken_t3", seen[3], RO | JJ);

    cu.instr = 8'h10;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    check("rst_mid_strobes", last_dut, 0);
    reset = 1'b0;
    cycle();
    check("rst_abort_t0", last_dut, CO | MI);
    repeat (4) cycle();

    exec(8'hB0, 0, 0, n);
    check("undef_len", n, 3);
    check("undef_t2", seen[2], 0);

    exec(8'hF0, 0, 0, n);
    check("hlt_len", n, 3);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("halt_quiet", last_dut, 0);
    end
    check("halted_flag", cu.halted, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("post_halt_t0", last_dut, CO | MI);
    check("post_halt_clear", cu.halted, 0);
    repeat (2) cycle();

    for (int k = 0; k < 300; k++) begin
      logic [3:0] opc;
      opc = 4'($urandom_range(0, 15));
      if (opc == 4'hF && $urandom_range(0, 3) != 0) opc = 4'h4;
      if ($urandom_range(0, 19) == 0) begin
        cu.instr = {opc, 4'($urandom)};
        repeat ($urandom_range(0, 3)) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        while (m_pos != 0) cycle();
      end else begin
        exec({opc, 4'($urandom)}, 1'($urandom), 1'($urandom), n);
      end
      if (m_halted) begin
        repeat ($urandom_range(1, 5)) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
      end
    end

    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
